// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-through, no-write-allocate data cache with load extension.
// Optional hit/miss statistics are enabled by defining DCACHE_STATS_EN.
module data_cache #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SETS       = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_read,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [2:0]            SizeCtr,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  stall,
    output logic                  misaligned,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [2:0]            mem_size,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    input  logic                  mem_ready,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
);
    localparam int IW = $clog2(SETS);
    localparam int TW = ADDR_WIDTH - 2 - IW;

    typedef enum logic [1:0] {IDLE, FILL, RESP, WRITE} state_t;

    state_t          state_q, state_d;
    logic [SETS-1:0] valid_q;
    logic [TW-1:0]   tag_q [SETS];
    logic [31:0]     data_q [SETS];

    logic [1:0]    off;
    logic [IW-1:0] idx;
    logic [TW-1:0] tag;
    logic [31:0]   line, ext, wd, merged;
    logic [15:0]   lh;
    logic [7:0]    lb;
    logic [3:0]    be;
    logic          size_mis, mis, hit, load_hit, fill_done, write_done;

    assign off = address[1:0];
    assign idx = address[2 +: IW];
    assign tag = address[ADDR_WIDTH-1 -: TW];
    assign line = data_q[idx];

    // Undefined size codes are rejected the same way as misaligned accesses.
    assign size_mis = SizeCtr == 3'b010 ? |off :
                      (SizeCtr == 3'b001 || SizeCtr == 3'b101) ? off[0] :
                      !(SizeCtr == 3'b000 || SizeCtr == 3'b100);
    assign mis = size_mis && (req_read || req_write);
    assign hit = valid_q[idx] && tag_q[idx] == tag;
    assign load_hit = state_q == IDLE && req_read && !req_write && !mis && hit;
    assign fill_done = state_q == FILL && mem_ready;
    assign write_done = state_q == WRITE && mem_ready;

    always_comb begin
        state_d = state_q == IDLE ? (mis ? IDLE : req_write ? WRITE : (req_read && !hit) ? FILL : IDLE) :
                  state_q == FILL ? (mem_ready ? RESP : FILL) :
                  state_q == RESP ? IDLE :
                  (mem_ready ? IDLE : WRITE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            if (fill_done) valid_q[idx] <= 1'b1;
        end
    end

    // Store data is right-aligned; replicate it so every lane sees its bytes.
    always_comb begin
        be = SizeCtr[1:0] == 2'b10 ? 4'hF : SizeCtr[0] ? (off[1] ? 4'hC : 4'h3) : 4'b0001 << off;
        wd = SizeCtr[1:0] == 2'b10 ? write_data : SizeCtr[0] ? {2{write_data[15:0]}} : {4{write_data[7:0]}};
    end

    for (genvar i = 0; i < 4; i++) begin : g_merge
        assign merged[8*i +: 8] = be[i] ? wd[8*i +: 8] : line[8*i +: 8];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (fill_done) begin
                tag_q[idx]  <= tag;
                data_q[idx] <= mem_read_data;
            end else if (write_done && hit) begin
                data_q[idx] <= merged;
            end
        end
    end

    always_comb begin
        lb = line[{off, 3'b000} +: 8];
        lh = off[1] ? line[31:16] : line[15:0];
        ext = SizeCtr[1] ? line :
              SizeCtr[0] ? {{16{lh[15] & ~SizeCtr[2]}}, lh} : {{24{lb[7] & ~SizeCtr[2]}}, lb};
    end

    assign read_data = (load_hit || state_q == RESP) ? ext : '0;
    assign stall = state_q == FILL || (state_q == WRITE && !mem_ready) ||
                   (state_q == IDLE && !mis && (req_write || (req_read && !hit)));
    assign misaligned = mis;
    assign mem_read = state_q == FILL;
    assign mem_write = state_q == WRITE;
    assign mem_address = mem_read ? {address[ADDR_WIDTH-1:2], 2'b00} : mem_write ? address : '0;
    assign mem_size = mem_read ? 3'b010 : mem_write ? SizeCtr : 3'b000;
    assign mem_write_data = mem_write ? write_data : '0;

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_q, hit_d, miss_q, miss_d;

    always_comb begin
        hit_d = (load_hit && ~&hit_q) ? hit_q + 32'd1 : hit_q;
        miss_d = (fill_done && ~&miss_q) ? miss_q + 32'd1 : miss_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else begin
            hit_q  <= hit_d;
            miss_q <= miss_d;
        end
    end

    assign hit_count = hit_q;
    assign miss_count = miss_q;
`else
    assign hit_count = '0;
    assign miss_count = '0;
`endif
endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: randomized and directed checks of data_cache against a word-level cache/memory model.
module tb_data_cache;
    logic        clk = 1'b0;
    logic        rst, req_read, req_write, mem_ready;
    logic [31:0] address, write_data, read_data, mem_address, mem_write_data, mem_read_data;
    logic [31:0] hit_count, miss_count;
    logic [2:0]  SizeCtr, mem_size;
    logic        stall, misaligned, mem_read, mem_write;

    int total = 0;
    int bad = 0;
    logic [31:0] memw [1024];
    logic [31:0] ref_mem [1024];
    int ref_line [64];
    int exp_hits, exp_miss;
`ifdef DCACHE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    data_cache dut (
        .clk(clk), .rst(rst), .req_read(req_read), .req_write(req_write), .address(address),
        .SizeCtr(SizeCtr), .write_data(write_data), .read_data(read_data), .stall(stall),
        .misaligned(misaligned), .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_size(mem_size), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data), .mem_ready(mem_ready), .hit_count(hit_count),
        .miss_count(miss_count)
    );

    always #5 clk = ~clk;
    assign mem_read_data = memw[mem_address[11:2]];

    function automatic bit is_mis(input logic [31:0] a, input logic [2:0] sz);
        case (sz)
            3'b000, 3'b100: return 1'b0;
            3'b001, 3'b101: return a[0];
            3'b010:         return a[1:0] != 2'b00;
            default:        return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] ext(input logic [31:0] w, input logic [1:0] off, input logic [2:0] sz);
        int unsigned v;
        if (sz == 3'b010) return w;
        if (sz[0] == 1'b0) begin
            v = (w >> (8 * off)) & 255;
            if (sz == 3'b000 && v >= 128) v = v - 256;
        end else begin
            v = (w >> (16 * off[1])) & 65535;
            if (sz == 3'b001 && v >= 32768) v = v - 65536;
        end
        return v;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] a,
                                          input logic [2:0] sz, input logic [31:0] d);
        logic [31:0] r = w;
        if (sz == 3'b010) r = d;
        else if (sz[0]) r[16*a[1] +: 16] = d[15:0];
        else r[8*a[1:0] +: 8] = d[7:0];
        return r;
    endfunction

    task automatic reset_model();
        for (int i = 0; i < 64; i++) ref_line[i] = -1;
        exp_hits = 0;
        exp_miss = 0;
    endtask

    task automatic wait_unstall(output int stalls);
        stalls = 0;
        forever begin
            @(negedge clk);
            if (!stall) break;
            stalls++;
            if (stalls > 20) begin
                total++; bad++;
                $display("FAIL stall_timeout addr=%h stall still 1 after %0d cycles, required release", address, stalls);
                break;
            end
        end
    endtask

    task automatic do_load(input logic [31:0] a, input logic [2:0] sz, output logic [31:0] got);
        bit m = is_mis(a, sz);
        int w = int'(a >> 2);
        bit h = !m && ref_line[w % 64] == w;
        int es = (m || h) ? 0 : 2;
        logic [31:0] ev = m ? 32'h0 : ext(ref_mem[w % 1024], a[1:0], sz);
        int stalls;
        req_read = 1'b1; req_write = 1'b0; address = a; SizeCtr = sz;
        wait_unstall(stalls);
        total++;
        if (stalls !== es) begin bad++; $display("FAIL load_stalls addr=%h sz=%b got=%0d exp=%0d", a, sz, stalls, es); end
        total++;
        if (read_data !== ev) begin bad++; $display("FAIL load_data addr=%h sz=%b got=%h exp=%h", a, sz, read_data, ev); end
        total++;
        if (misaligned !== m) begin bad++; $display("FAIL load_misaligned addr=%h sz=%b got=%b exp=%b", a, sz, misaligned, m); end
        total++;
        if ({mem_read, mem_write} !== 2'b00) begin bad++; $display("FAIL load_strobes addr=%h got=%b exp=00", a, {mem_read, mem_write}); end
        got = read_data;
        if (!m) begin
            if (h) exp_hits++;
            else begin exp_miss++; ref_line[w % 64] = w; end
        end
        @(posedge clk); #1;
        req_read = 1'b0;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
        bit m = is_mis(a, sz);
        int w = int'(a >> 2);
        int stalls;
        req_read = 1'b0; req_write = 1'b1; address = a; SizeCtr = sz; write_data = d;
        wait_unstall(stalls);
        total++;
        if (stalls !== (m ? 0 : 1)) begin bad++; $display("FAIL store_stalls addr=%h got=%0d exp=%0d", a, stalls, m ? 0 : 1); end
        total++;
        if (mem_write !== !m) begin bad++; $display("FAIL store_strobe addr=%h got=%b exp=%b", a, mem_write, !m); end
        if (mem_write === 1'b1) memw[mem_address[11:2]] = merge(memw[mem_address[11:2]], mem_address, mem_size, mem_write_data);
        if (!m) ref_mem[w % 1024] = merge(ref_mem[w % 1024], a, sz, d);
        total++;
        if (memw[w % 1024] !== ref_mem[w % 1024]) begin
            bad++; $display("FAIL store_memory addr=%h got=%h exp=%h", a, memw[w % 1024], ref_mem[w % 1024]);
        end
        @(posedge clk); #1;
        req_write = 1'b0;
    endtask

    task automatic check_counters(input string name);
        total++;
        if (hit_count !== (STATS ? exp_hits : 0) || miss_count !== (STATS ? exp_miss : 0)) begin
            bad++;
            $display("FAIL %s hits=%0d misses=%0d exp hits=%0d misses=%0d", name, hit_count, miss_count,
                     STATS ? exp_hits : 0, STATS ? exp_miss : 0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_read = 1'b0; req_write = 1'b0; mem_ready = 1'b1;
        address = '0; SizeCtr = '0; write_data = '0;
        reset_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({stall, misaligned, mem_read, mem_write} !== 4'b0 || read_data !== 0 || mem_address !== 0 ||
            mem_size !== 0 || mem_write_data !== 0 || hit_count !== 0 || miss_count !== 0) begin
            bad++;
            $display("FAIL reset_outputs stall=%b mis=%b rd=%b wr=%b data=%h maddr=%h cnt=%0d/%0d exp all 0",
                     stall, misaligned, mem_read, mem_write, read_data, mem_address, hit_count, miss_count);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_fill_hit();
        logic [31:0] got;
        memw[32] = 32'hDEADBEEF; ref_mem[32] = 32'hDEADBEEF;
        do_load(32'h80, 3'b010, got);
        total++;
        if (got !== 32'hDEADBEEF) begin bad++; $display("FAIL fill_word got=%h exp=deadbeef", got); end
        do_load(32'h80, 3'b010, got);
        total++;
        if (got !== 32'hDEADBEEF) begin bad++; $display("FAIL hit_word got=%h exp=deadbeef", got); end
    endtask

    task automatic test_extend();
        logic [31:0] got;
        logic [31:0] addrs [4] = '{32'h83, 32'h83, 32'h80, 32'h82};
        logic [2:0]  sizes [4] = '{3'b000, 3'b100, 3'b101, 3'b001};
        logic [31:0] exps  [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'h0000BEEF, 32'hFFFFDEAD};
        for (int i = 0; i < 4; i++) begin
            do_load(addrs[i], sizes[i], got);
            total++;
            if (got !== exps[i]) begin bad++; $display("FAIL extend_%0d got=%h exp=%h", i, got, exps[i]); end
        end
    endtask

    task automatic test_store_hit();
        logic [31:0] got;
        do_store(32'h81, 3'b000, 32'h11);
        @(negedge clk);
        total++;
        if (mem_write !== 1'b0) begin bad++; $display("FAIL store_one_cycle mem_write got=%b exp=0", mem_write); end
        do_load(32'h80, 3'b010, got);
        total++;
        if (got !== 32'hDEAD11EF) begin bad++; $display("FAIL store_merge got=%h exp=dead11ef", got); end
    endtask

    task automatic test_store_miss();
        logic [31:0] got;
        do_store(32'h200, 3'b010, 32'hCAFEF00D);
        total++;
        if (memw[128] !== 32'hCAFEF00D) begin bad++; $display("FAIL store_miss_mem got=%h exp=cafef00d", memw[128]); end
        do_load(32'h200, 3'b010, got);
        total++;
        if (got !== 32'hCAFEF00D) begin bad++; $display("FAIL store_miss_load got=%h exp=cafef00d", got); end
    endtask

    task automatic test_misaligned();
        logic [31:0] got;
        do_load(32'h82, 3'b010, got);
        do_load(32'h81, 3'b101, got);
        do_load(32'h80, 3'b111, got);
        do_store(32'h83, 3'b001, 32'h1234);
    endtask

    task automatic test_reset_in_fill();
        logic [31:0] got;
        mem_ready = 1'b0;
        req_read = 1'b1; address = 32'h343; SizeCtr = 3'b000;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (mem_read !== 1'b1 || stall !== 1'b1 || mem_address !== 32'h340 || mem_size !== 3'b010) begin
                bad++;
                $display("FAIL fill_hold rd=%b stall=%b maddr=%h size=%b exp 1 1 340 010", mem_read, stall, mem_address, mem_size);
            end
        end
        @(posedge clk); #1;
        rst = 1'b1; req_read = 1'b0; mem_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (mem_read !== 1'b0 || stall !== 1'b0) begin
            bad++; $display("FAIL reset_in_fill rd=%b stall=%b exp 0 0", mem_read, stall);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        reset_model();
        check_counters("counters_after_reset");
        do_load(32'h340, 3'b010, got);
    endtask

    task automatic test_counters();
        logic [31:0] got;
        do_load(32'h80, 3'b010, got);
        for (int i = 0; i < 3; i++) do_load(32'h80 + i, 3'b100, got);
        check_counters("counters_directed");
    endtask

    task automatic test_back_to_back();
        logic [31:0] got;
        logic [2:0] sizes [8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110};
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a = ($urandom_range(0, 7) << 8) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            logic [2:0] sz = sizes[$urandom_range(0, 7)];
            if ($urandom_range(0, 3) == 0) do_store(a, sz, $urandom);
            else do_load(a, sz, got);
        end
        check_counters("counters_random");
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            memw[i] = $urandom;
            ref_mem[i] = memw[i];
        end
        test_reset();
        test_fill_hit();
        test_extend();
        test_store_hit();
        test_store_miss();
        test_misaligned();
        test_reset_in_fill();
        test_counters();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/data_cache.md
# data_cache

Direct-mapped, write-through, no-write-allocate data cache between the core's load/store stage and `MainMemory`. It:

- services load hits combinationally;
- fills one 32-bit word line from memory on a load miss;
- forwards every store to memory unchanged.

It also produces the final sign- or zero-extended load value, so the core never consumes raw memory byte lanes.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, byte-address width.
- `DATA_WIDTH`, 32, word width; only 32 is supported.
- `SETS`, 64, number of lines; must be a power of two and at least 2.

Ports:
- `clk` in 1: single clock. Everything updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req_read` in 1: load request, held until `stall`=0.
- `req_write` in 1: store request, held until `stall`=0.
- `address` in ADDR_WIDTH: byte address of the access.
- `SizeCtr` in 3: access size.
  - 000 = byte, signed; 001 = half, signed; 010 = word.
  - 100 = byte, unsigned; 101 = half, unsigned.
- `write_data` in 32: store data, right-aligned.
- `read_data` out 32: extended load result. Valid when `req_read`=1 and `stall`=0; 0 otherwise.
- `stall` out 1: core must hold its request.
- `misaligned` out 1: the current request is misaligned.
- `mem_read`, `mem_write` out 1: memory strobes.
- `mem_address` out ADDR_WIDTH: memory address.
- `mem_size` out 3: size code passed to memory.
- `mem_write_data` out 32: data passed to memory.
- `mem_read_data` in 32: memory return data.
- `mem_ready` in 1: memory handshake.
- `hit_count`, `miss_count` out 32: statistics (see Configuration).

## Operation
- Address split: offset = `address[1:0]`; index = `address[2 +: log2(SETS)]`; tag = remaining upper bits.
- Per-line storage: valid bit, tag, and a 32-bit word.
- States:
  - IDLE: accepts requests.
  - FILL: line refill from memory.
  - RESP: returns the refilled data.
  - WRITE: store forwarded to memory.
- IDLE behaviour:
  - Load hit: `stall`=0, `read_data` extracted from the line this cycle. No memory access.
  - Load miss: `stall`=1, next state FILL.
  - Store: `stall`=1, next state WRITE.
  - If `req_read` and `req_write` are both high, the store wins.
- FILL: drive `mem_read`=1, `mem_address`={addr[ADDR_WIDTH-1:2],2'b00}, `mem_size`=010. On the edge where `mem_ready`=1, write the line (valid=1, tag, word) and go to RESP.
- RESP: `stall`=0, `read_data` taken from the refilled line; next state IDLE.
- WRITE: drive `mem_write`=1, `mem_address`=`address`, `mem_size`=`SizeCtr`, `mem_write_data`=`write_data`.
  - When `mem_ready`=1: `stall`=0; on a hit, merge the written bytes into the line; next state IDLE.
  - A miss leaves the cache unchanged.
- Load extraction: byte lane = offset; half lane = offset[1]. Sign-extend for 000/001, zero-extend for 100/101.
- Misalignment: a half access with offset[0]=1, or a word access with offset≠0, is misaligned.
  - `misaligned`=1, `stall`=0, no memory access, no state change, `read_data`=0.
  - `SizeCtr` values 011, 110 and 111 are handled identically.
- Memory strobes are 0 outside FILL and WRITE. `mem_address`, `mem_size` and `mem_write_data` are 0 when no strobe is active.

## Timing
- Reset: state = IDLE, all valid bits = 0.
  - All outputs are 0; `stall` is 0 unless a request is present.
  - Counters are 0.
- Reset during FILL or WRITE: the line is not updated. Strobes drop in the first cycle after the reset edge.
- Latency with `mem_ready` held at 1:
  - Load hit: 0 stall cycles.
  - Load miss: 2 stall cycles (IDLE, FILL), data in RESP.
  - Store: 1 stall cycle (IDLE), completes in WRITE.
- `mem_ready`=0 holds FILL/WRITE indefinitely with strobes steady and `stall`=1.
- Index aliasing: a miss to the same index replaces the line.

## Configuration
- `DCACHE_STATS_EN` defined:
  - `hit_count` increments once per completed load hit.
  - `miss_count` increments once per FILL completion.
  - Both saturate at 0xFFFFFFFF and are cleared by `rst`.
- Not defined: counter logic is absent and both ports are tied to 0.

## Test plan
- Reset, then memory word 0x80 = 0xDEADBEEF; load word 0x80 -> 2 stall cycles, `read_data`=0xDEADBEEF. Reloading the same address gives 0 stalls and the same data.
- After the line is filled: SizeCtr 000 at 0x83 -> 0xFFFFFFDE; 100 at 0x83 -> 0x000000DE; 101 at 0x80 -> 0x0000BEEF; 001 at 0x82 -> 0xFFFFDEAD.
- Store byte 0x11 to 0x81 (hit) -> `mem_write` for 1 cycle with `mem_size`=000; then load word 0x80 hits and returns 0xDEAD11EF.
- Store word to uncached 0x200 -> memory updated, line stays invalid; next load of 0x200 misses.
- Misaligned word load at 0x82 -> `misaligned`=1, `stall`=0, no strobe.
- Assert `rst` in FILL -> next cycle IDLE, `mem_read`=0. With `DCACHE_STATS_EN`: 3 hits and 1 miss give counters 3 and 1.
